// File: rtl/sv32_tlb.sv
// Fully associative Sv32 TLB in front of the page-table walker.
// Define TLB_STATS_EN to add hit_count/miss_count statistics ports.
module sv32_tlb #(
    parameter int unsigned ENTRIES = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [31:0] req_vaddr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_paddr,
    output logic        resp_fault,
    output logic        walk_req,
    output logic [31:0] walk_vaddr,
    input  logic        walk_done,
    input  logic        walk_fault,
    input  logic [19:0] walk_ppn,
    input  logic        walk_superpage,
    input  logic        flush
`ifdef TLB_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned IdxW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {StIdle, StLookup, StWalk, StResp} state_e;

    state_e              state_q, state_d;
    logic [31:0]         vaddr_q;
    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  super_q;
    logic [19:0]         vpn_q [ENTRIES];
    logic [19:0]         ppn_q [ENTRIES];
    logic [IdxW-1:0]     rr_q;
    logic                flush_seen_q, flush_seen_d;
    logic                ready_q;
    logic [31:0]         paddr_q;
    logic                fault_q;

    logic                hit;
    logic [31:0]         hit_paddr;
    logic [IdxW-1:0]     victim;
    logic                use_rr;
    logic                fill;
    logic [31:0]         walk_paddr;

    // At most one entry can match, so OR-reducing the per-entry addresses is a mux.
    always_comb begin
        hit       = 1'b0;
        hit_paddr = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            if (valid_q[i] && (super_q[i] ? (vpn_q[i][19:10] == vaddr_q[31:22])
                                          : (vpn_q[i] == vaddr_q[31:12]))) begin
                hit       = 1'b1;
                hit_paddr = hit_paddr | (super_q[i] ? {ppn_q[i][19:10], vaddr_q[21:0]}
                                                    : {ppn_q[i], vaddr_q[11:0]});
            end
        end
    end

    // Lowest-index invalid entry wins; round-robin only once the table is full.
    always_comb begin
        victim = rr_q;
        use_rr = 1'b1;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                victim = IdxW'(i);
                use_rr = 1'b0;
            end
        end
    end

    assign fill = (state_q == StWalk) && walk_done && !walk_fault && !flush_seen_q && !flush;
    assign walk_paddr = walk_superpage ? {walk_ppn[19:10], vaddr_q[21:0]}
                                       : {walk_ppn, vaddr_q[11:0]};

    always_comb begin
        state_d      = state_q;
        flush_seen_d = flush_seen_q;
        case (state_q)
            StIdle:   if (req_valid && ready_q) state_d = StLookup;
            StLookup: state_d = hit ? StIdle : StWalk;
            StWalk:   if (walk_done) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (state_q == StWalk && flush) flush_seen_d = 1'b1;
        if (state_d == StIdle) flush_seen_d = 1'b0;
    end

    always_comb begin
        req_ready  = ready_q;
        resp_valid = 1'b0;
        resp_paddr = '0;
        resp_fault = 1'b0;
        walk_req   = (state_q == StWalk);
        walk_vaddr = '0;
        if (state_q == StLookup && hit) begin
            resp_valid = 1'b1;
            resp_paddr = hit_paddr;
        end else if (state_q == StResp) begin
            resp_valid = 1'b1;
            resp_paddr = paddr_q;
            resp_fault = fault_q;
        end
        if (walk_req) walk_vaddr = vaddr_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            vaddr_q      <= '0;
            flush_seen_q <= 1'b0;
            ready_q      <= 1'b0;
            paddr_q      <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_seen_q <= flush_seen_d;
            // Registered so that req_ready is also 0 while reset is held.
            ready_q      <= (state_d == StIdle);
            if (state_q == StIdle && req_valid && ready_q) vaddr_q <= req_vaddr;
            if (state_q == StWalk && walk_done) begin
                paddr_q <= walk_fault ? 32'h0 : walk_paddr;
                fault_q <= walk_fault;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            super_q <= '0;
            rr_q    <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                vpn_q[i] <= '0;
                ppn_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                valid_q <= '0;
            end else if (fill) begin
                valid_q[victim] <= 1'b1;
            end
            if (fill) begin
                vpn_q[victim]   <= vaddr_q[31:12];
                ppn_q[victim]   <= walk_ppn;
                super_q[victim] <= walk_superpage;
                if (use_rr) rr_q <= rr_q + IdxW'(1);
            end
        end
    end

`ifdef TLB_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == StLookup) begin
            if (hit) hit_count <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
